axi4_burst_slave: RTL and testbench

AXI4_BURST_SLAVE -- requirements
Module: axi4_burst_slave

---
 rtl/axi4_pkg.sv | 27 ++
 rtl/axi4_burst_addr_gen.sv | 49 ++++
 rtl/axi4_burst_slave.sv | 222 ++++++++++++++++++++++
 tb/tb_axi4_burst_slave.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 burst-slave definitions.
//   burst_t   : AXI burst encodings (FIXED, INCR, WRAP); 2'b11 is reserved.
//   OKAY/SLVERR : response encodings used on bresp and rresp.
//   w_state_t / r_state_t : write- and read-channel FSM states.
package axi4_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Burst address generator (purely combinational, one per channel).
//   addr      : word address of the current beat
//   len       : burst length minus one (AxLEN)
//   burst     : burst type (AxBURST)
//   next_addr : word address of the following beat
//   beat_err  : current beat must be answered with SLVERR (illegal burst
//               type, illegal WRAP length, or address outside storage)
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int ASZ    = 4,
  parameter int NWORDS = 12
) (
  input  logic [ASZ-1:0] addr,
  input  logic [7:0]     len,
  input  logic [1:0]     burst,
  output logic [ASZ-1:0] next_addr,
  output logic           beat_err
);

  localparam logic [ASZ:0] NWORDS_W = (ASZ+1)'(NWORDS);

  logic [ASZ-1:0] addr_inc;
  logic [ASZ-1:0] wrap_mask;
  logic           burst_err;
  logic           in_range;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    addr_inc  = addr + 1'b1;
    // A legal WRAP length is 2**k-1, so len itself is the in-block offset mask.
    wrap_mask = ASZ'(len);
    next_addr = addr;
    burst_err = 1'b0;
    case (burst)
      FIXED: next_addr = addr;
      INCR:  next_addr = addr_inc;
      WRAP: begin
        next_addr = (addr & ~wrap_mask) | (addr_inc & wrap_mask);
        burst_err = !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
      end
      default: burst_err = 1'b1;
    endcase
    in_range = {1'b0, addr} < NWORDS_W;
    beat_err = burst_err || !in_range;
  end

endmodule

// File: rtl/axi4_burst_slave.sv
// AXI4 burst slave backed by NWORDS x DSZ registers.
//   clk, _rst            : clock, asynchronous active-low reset
//   aw*/w*/b*            : write address, data and response channels
//   ar*/r*               : read address and data channels
// Addresses are word addresses. Write and read channels run independently;
// a read and a write of the same word on the same edge returns the old value.
module axi4_burst_slave
  import axi4_pkg::*;
#(
  parameter int DSZ    = 32,
  parameter int ASZ    = 4,
  parameter int NWORDS = 12
) (
  input  logic             clk,
  input  logic             _rst,
  // write address
  input  logic [ASZ-1:0]   awaddr,
  input  logic [7:0]       awlen,
  input  logic [1:0]       awburst,
  input  logic             awvalid,
  output logic             awready,
  // write data
  input  logic [DSZ-1:0]   wdata,
  input  logic [DSZ/8-1:0] wstrb,
  input  logic             wlast,
  input  logic             wvalid,
  output logic             wready,
  // write response
  output logic [1:0]       bresp,
  output logic             bvalid,
  input  logic             bready,
  // read address
  input  logic [ASZ-1:0]   araddr,
  input  logic [7:0]       arlen,
  input  logic [1:0]       arburst,
  input  logic             arvalid,
  output logic             arready,
  // read data
  output logic [DSZ-1:0]   rdata,
  output logic [1:0]       rresp,
  output logic             rlast,
  output logic             rvalid,
  input  logic             rready
);

  localparam int NBYTES = DSZ / 8;

  logic [DSZ-1:0] mem [NWORDS];

  // ---------------- write channel ----------------
  w_state_t       w_state;
  logic [ASZ-1:0] w_addr;
  logic [7:0]     w_len;
  logic [1:0]     w_burst;
  logic [8:0]     w_cnt;      // beats accepted so far, saturating
  logic           w_err;      // an earlier beat of this burst errored
  logic [ASZ-1:0] w_next_addr;
  logic           w_beat_err;
  logic           w_in_burst;
  logic           w_beat_bad;
  logic           mem_we;

  axi4_burst_addr_gen #(.ASZ(ASZ), .NWORDS(NWORDS)) u_w_gen (
    .addr      (w_addr),
    .len       (w_len),
    .burst     (w_burst),
    .next_addr (w_next_addr),
    .beat_err  (w_beat_err)
  );

  assign w_in_burst = w_cnt <= {1'b0, w_len};
  assign w_beat_bad = !w_in_burst || w_beat_err;
  assign mem_we     = (w_state == W_DATA) && wvalid && wready && !w_beat_bad;

  // NOTE: sequential state is assigned with <= only, so every register
  // samples pre-edge values and block ordering cannot change the result.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      w_state <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
      w_addr  <= '0;
      w_len   <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid) begin
            w_state <= W_DATA;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_burst <= awburst;
            w_cnt   <= '0;
            w_err   <= 1'b0;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            // Beats past len+1 are discarded and do not move the address.
            if (w_in_burst) w_addr <= w_next_addr;
            if (w_cnt != '1) w_cnt <= w_cnt + 9'd1;
            if (wlast) begin
              w_state <= W_RESP;
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= (w_err || w_beat_bad || (w_cnt != {1'b0, w_len}))
                         ? SLVERR : OKAY;
            end else begin
              w_err <= w_err || w_beat_bad;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            w_state <= W_IDLE;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
            awready <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the storage is cleared by reset because the design requires every
  // word to read back as zero afterwards; plain RAMs usually are not reset.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < NBYTES; b++)
        if (wstrb[b]) mem[w_addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // ---------------- read channel ----------------
  r_state_t       r_state;
  logic [ASZ-1:0] r_next_addr;  // address of the beat to present next
  logic [7:0]     r_len;
  logic [1:0]     r_burst;
  logic [7:0]     r_cnt;        // index of the beat currently presented
  logic [ASZ-1:0] rg_addr;
  logic [7:0]     rg_len;
  logic [1:0]     rg_burst;
  logic [ASZ-1:0] rg_next;
  logic           rg_err;
  logic [DSZ-1:0] rg_data;

  // While idle the generator looks at the AR request so beat 0 can be
  // loaded on the handshake edge; afterwards it follows the burst.
  assign rg_addr  = (r_state == R_IDLE) ? araddr  : r_next_addr;
  assign rg_len   = (r_state == R_IDLE) ? arlen   : r_len;
  assign rg_burst = (r_state == R_IDLE) ? arburst : r_burst;
  assign rg_data  = rg_err ? '0 : mem[rg_addr];

  axi4_burst_addr_gen #(.ASZ(ASZ), .NWORDS(NWORDS)) u_r_gen (
    .addr      (rg_addr),
    .len       (rg_len),
    .burst     (rg_burst),
    .next_addr (rg_next),
    .beat_err  (rg_err)
  );

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_state     <= R_IDLE;
      arready     <= 1'b1;
      rvalid      <= 1'b0;
      rdata       <= '0;
      rresp       <= OKAY;
      rlast       <= 1'b0;
      r_next_addr <= '0;
      r_len       <= '0;
      r_burst     <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            r_state     <= R_DATA;
            arready     <= 1'b0;
            rvalid      <= 1'b1;
            rdata       <= rg_data;
            rresp       <= rg_err ? SLVERR : OKAY;
            rlast       <= (arlen == 8'd0);
            r_len       <= arlen;
            r_burst     <= arburst;
            r_cnt       <= '0;
            r_next_addr <= rg_next;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              r_state <= R_IDLE;
              arready <= 1'b1;
              rvalid  <= 1'b0;
              rdata   <= '0;
              rresp   <= OKAY;
              rlast   <= 1'b0;
            end else begin
              rdata       <= rg_data;
              rresp       <= rg_err ? SLVERR : OKAY;
              rlast       <= (r_cnt + 8'd1 == r_len);
              r_cnt       <= r_cnt + 8'd1;
              r_next_addr <= rg_next;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_burst_slave.sv
// Directed testbench for axi4_burst_slave (DSZ=32, ASZ=4, NWORDS=12).
module tb_axi4_burst_slave;

  localparam int DSZ    = 32;
  localparam int ASZ    = 4;
  localparam int NWORDS = 12;
  localparam int LIMIT  = 40;

  logic            clk  = 1'b0;
  logic            _rst = 1'b1;
  logic [ASZ-1:0]  awaddr = '0;
  logic [7:0]      awlen = '0;
  logic [1:0]      awburst = '0;
  logic            awvalid = 1'b0;
  logic            awready;
  logic [DSZ-1:0]  wdata = '0;
  logic [DSZ/8-1:0] wstrb = '0;
  logic            wlast = 1'b0;
  logic            wvalid = 1'b0;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready = 1'b0;
  logic [ASZ-1:0]  araddr = '0;
  logic [7:0]      arlen = '0;
  logic [1:0]      arburst = '0;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [DSZ-1:0]  rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready = 1'b0;

  axi4_burst_slave #(.DSZ(DSZ), .ASZ(ASZ), .NWORDS(NWORDS)) dut (
    .clk     (clk),
    ._rst    (_rst),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awburst (awburst),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arlen   (arlen),
    .arburst (arburst),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] wd [16];
  logic [31:0] rd_data [64];
  logic [1:0]  rd_resp [64];
  logic        rd_last [64];
  int          rd_n;
  logic [1:0]  bresp_got;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL timeout_%s: observed=no handshake expected=handshake", tag);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] len, input logic [1:0] burst,
                          input int nbeats, input logic [3:0] strb, output logic [1:0] resp);
    int n;
    awaddr = a; awlen = len; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < LIMIT) begin @(posedge clk); #1; n++; end
    if (n >= LIMIT) timeout("aw");
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = wd[i]; wstrb = strb; wlast = (i == nbeats - 1); wvalid = 1'b1;
      n = 0;
      while (wready !== 1'b1 && n < LIMIT) begin @(posedge clk); #1; n++; end
      if (n >= LIMIT) timeout("w");
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    n = 0;
    while (bvalid !== 1'b1 && n < LIMIT) begin @(posedge clk); #1; n++; end
    if (n >= LIMIT) timeout("b");
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] len, input logic [1:0] burst);
    int n;
    bit done;
    araddr = a; arlen = len; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < LIMIT) begin @(posedge clk); #1; n++; end
    if (n >= LIMIT) timeout("ar");
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready = 1'b1;
    rd_n = 0; done = 1'b0; n = 0;
    while (!done && n < LIMIT) begin
      if (rvalid === 1'b1) begin
        rd_data[rd_n] = rdata;
        rd_resp[rd_n] = rresp;
        rd_last[rd_n] = rlast;
        rd_n++;
        done = (rlast === 1'b1);
      end
      @(posedge clk); #1;
      n++;
    end
    rready = 1'b0;
    if (!done) timeout("r");
  endtask

  initial begin
    int n;
    // ---- reset ----
    _rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_wready",  32'(wready),  32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_bresp",   32'(bresp),   32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_rdata",   rdata,        32'd0);
    check("rst_rlast",   32'(rlast),   32'd0);
    _rst = 1'b1;
    @(posedge clk); #1;

    // ---- INCR write addr 2 len 3, then INCR read back ----
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    do_write(4'd2, 8'd3, 2'b01, 4, 4'hF, bresp_got);
    check("incr_wr_bresp", 32'(bresp_got), 32'd0);
    do_read(4'd2, 8'd3, 2'b01);
    check("incr_rd_beats", 32'(rd_n), 32'd4);
    check("incr_rd_d0", rd_data[0], 32'h11);
    check("incr_rd_d1", rd_data[1], 32'h22);
    check("incr_rd_d2", rd_data[2], 32'h33);
    check("incr_rd_d3", rd_data[3], 32'h44);
    check("incr_rd_resp", 32'({rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]}), 32'h00);
    check("incr_rd_last", 32'({rd_last[0], rd_last[1], rd_last[2], rd_last[3]}), 32'b0001);
    check("rd_done_rvalid",  32'(rvalid),  32'd0);
    check("rd_done_rdata",   rdata,        32'd0);
    check("rd_done_arready", 32'(arready), 32'd1);

    // ---- WRAP read addr 6 len 3 -> 6,7,4,5 ----
    wd[0] = 32'h40; wd[1] = 32'h50; wd[2] = 32'h60; wd[3] = 32'h70;
    do_write(4'd4, 8'd3, 2'b01, 4, 4'hF, bresp_got);
    check("wrap_prep_bresp", 32'(bresp_got), 32'd0);
    do_read(4'd6, 8'd3, 2'b10);
    check("wrap_rd_beats", 32'(rd_n), 32'd4);
    check("wrap_rd_d0", rd_data[0], 32'h60);
    check("wrap_rd_d1", rd_data[1], 32'h70);
    check("wrap_rd_d2", rd_data[2], 32'h40);
    check("wrap_rd_d3", rd_data[3], 32'h50);
    check("wrap_rd_last", 32'({rd_last[0], rd_last[1], rd_last[2], rd_last[3]}), 32'b0001);

    // ---- partial strobe on word 0 ----
    wd[0] = 32'hAABBCCDD;
    do_write(4'd0, 8'd0, 2'b01, 1, 4'hF, bresp_got);
    wd[0] = 32'h11223344;
    do_write(4'd0, 8'd0, 2'b01, 1, 4'b0101, bresp_got);
    check("strb_bresp", 32'(bresp_got), 32'd0);
    do_read(4'd0, 8'd0, 2'b01);
    check("strb_rd_d0", rd_data[0], 32'hAA22CC44);
    check("strb_rd_last", 32'(rd_last[0]), 32'd1);

    // ---- range error: INCR write addr 10 len 3, read addr 11 len 1 ----
    wd[0] = 32'hA1; wd[1] = 32'hA2; wd[2] = 32'hA3; wd[3] = 32'hA4;
    do_write(4'd10, 8'd3, 2'b01, 4, 4'hF, bresp_got);
    check("range_wr_bresp", 32'(bresp_got), 32'd2);
    do_read(4'd11, 8'd1, 2'b01);
    check("range_rd_beats", 32'(rd_n), 32'd2);
    check("range_rd_d0", rd_data[0], 32'hA2);
    check("range_rd_r0", 32'(rd_resp[0]), 32'd0);
    check("range_rd_d1", rd_data[1], 32'h0);
    check("range_rd_r1", 32'(rd_resp[1]), 32'd2);
    do_read(4'd10, 8'd0, 2'b01);
    check("range_rd_w10", rd_data[0], 32'hA1);

    // ---- illegal bursts: WRAP len 2 write, burst 11 read ----
    wd[0] = 32'hFFFF_FFFF; wd[1] = 32'hFFFF_FFFF; wd[2] = 32'hFFFF_FFFF;
    do_write(4'd0, 8'd2, 2'b10, 3, 4'hF, bresp_got);
    check("badwrap_bresp", 32'(bresp_got), 32'd2);
    do_read(4'd0, 8'd0, 2'b01);
    check("badwrap_nowrite", rd_data[0], 32'hAA22CC44);
    do_read(4'd0, 8'd1, 2'b11);
    check("bad11_beats", 32'(rd_n), 32'd2);
    check("bad11_data", rd_data[0] | rd_data[1], 32'h0);
    check("bad11_resp", 32'({rd_resp[0], rd_resp[1]}), 32'b1010);

    // ---- early wlast and extra beats ----
    wd[0] = 32'h81; wd[1] = 32'h82;
    do_write(4'd8, 8'd3, 2'b01, 2, 4'hF, bresp_got);
    check("early_last_bresp", 32'(bresp_got), 32'd2);
    wd[0] = 32'h111; wd[1] = 32'h222; wd[2] = 32'h333;
    do_write(4'd1, 8'd0, 2'b01, 3, 4'hF, bresp_got);
    check("extra_beats_bresp", 32'(bresp_got), 32'd2);
    do_read(4'd8, 8'd1, 2'b01);
    check("early_rd_w8", rd_data[0], 32'h81);
    check("early_rd_w9", rd_data[1], 32'h82);
    do_read(4'd1, 8'd1, 2'b01);
    check("extra_rd_w1", rd_data[0], 32'h111);
    check("extra_rd_w2", rd_data[1], 32'h11);

    // ---- FIXED burst ----
    wd[0] = 32'h5; wd[1] = 32'h6;
    do_write(4'd3, 8'd1, 2'b00, 2, 4'hF, bresp_got);
    check("fixed_bresp", 32'(bresp_got), 32'd0);
    do_read(4'd3, 8'd1, 2'b00);
    check("fixed_rd_d0", rd_data[0], 32'h6);
    check("fixed_rd_d1", rd_data[1], 32'h6);

    // ---- read backpressure: words 2..5 = 11,6,40,50 ----
    araddr = 4'd2; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (arready !== 1'b1 && n < LIMIT) begin @(posedge clk); #1; n++; end
    if (n >= LIMIT) timeout("bp_ar");
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("bp_b0", rdata, 32'h11);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("bp_b1", rdata, 32'h6);
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_hold_data",  rdata,         32'h6);
      check("bp_hold_valid", 32'(rvalid),   32'd1);
      check("bp_hold_last",  32'(rlast),    32'd0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    check("bp_b2", rdata, 32'h40);
    @(posedge clk); #1;
    check("bp_b3", rdata, 32'h50);
    check("bp_b3_last", 32'(rlast), 32'd1);
    @(posedge clk); #1;
    rready = 1'b0;
    check("bp_end_rvalid", 32'(rvalid), 32'd0);

    // ---- reset while in W_DATA ----
    awaddr = 4'd0; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < LIMIT) begin @(posedge clk); #1; n++; end
    if (n >= LIMIT) timeout("rstw_aw");
    @(posedge clk); #1;
    awvalid = 1'b0;
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    check("rstw_in_wdata", 32'(wready), 32'd1);
    _rst = 1'b0;
    #1;
    check("rstw_awready", 32'(awready), 32'd1);
    check("rstw_bvalid",  32'(bvalid),  32'd0);
    check("rstw_wready",  32'(wready),  32'd0);
    #12;
    _rst = 1'b1;
    @(posedge clk); #1;
    check("rstw_bvalid_after", 32'(bvalid), 32'd0);
    do_read(4'd0, 8'd11, 2'b01);
    check("rstw_rd_beats", 32'(rd_n), 32'd12);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("rstw_word%0d", i), rd_data[i], 32'h0);
    end
    check("rstw_rd_last", 32'(rd_last[11]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
